// File: rtl/alu_exec_ctrl_pkg.sv
// Shared definitions for the ALU issue/writeback controller: datapath default,
// ALU opcode encodings and the controller state type.
package alu_exec_ctrl_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_WB   = 2'b10
  } state_e;

endpackage

// File: rtl/alu_ctrl_regfile.sv
// Register file for the ALU controller: two operand read ports, a debug read
// port and one synchronous write port; r0 always reads as zero.
module alu_ctrl_regfile
  import alu_exec_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int DEPTH = 2 ** REG_AW;

  logic [DATA_W-1:0] mem_r [0:DEPTH-1];

  // Storage: cleared on reset, writes to r0 are dropped so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (we && (waddr != {REG_AW{1'b0}})) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata_a  = (raddr_a  == {REG_AW{1'b0}}) ? {DATA_W{1'b0}} : mem_r[raddr_a];
  assign rdata_b  = (raddr_b  == {REG_AW{1'b0}}) ? {DATA_W{1'b0}} : mem_r[raddr_b];
  assign dbg_data = (dbg_addr == {REG_AW{1'b0}}) ? {DATA_W{1'b0}} : mem_r[dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Issue/writeback controller for the 2-bit-op ALU: accepts one instruction,
// drives the ALU for one cycle, then writes the registered result back.
module alu_exec_ctrl
  import alu_exec_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = 3,
  parameter int IMM_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        instr_op,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_rs1,
  input  logic [REG_AW-1:0] instr_rs2,
  input  logic              instr_imm_en,
  input  logic [IMM_W-1:0]  instr_imm,
  output logic              alu_ena,
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  input  logic [DATA_W-1:0] alu_out,
  output logic              res_valid,
  output logic [REG_AW-1:0] res_rd,
  output logic [DATA_W-1:0] res_data,
  output logic [CNT_W-1:0]  retired_cnt,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_e              state_r, state_nxt_s;
  logic [1:0]          op_r;
  logic [REG_AW-1:0]   rd_r, rs1_r, rs2_r;
  logic                imm_en_r;
  logic [IMM_W-1:0]    imm_r;
  logic                res_valid_r;
  logic [REG_AW-1:0]   res_rd_r;
  logic [DATA_W-1:0]   res_data_r;
  logic [CNT_W-1:0]    retired_cnt_r;
  logic [DATA_W-1:0]   rs1_data_s, rs2_data_s;
  logic                instr_fire_s, wb_s;
  logic                instr_ready_s, alu_ena_s;
  logic [1:0]          alu_op_s;
  logic [DATA_W-1:0]   alu_x_s, alu_y_s;

  function automatic logic [DATA_W-1:0] sext(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

  assign instr_fire_s = (state_r == ST_IDLE) && instr_valid;
  assign wb_s         = (state_r == ST_WB);

  alu_ctrl_regfile #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (wb_s),
    .waddr    (rd_r),
    .wdata    (alu_out),
    .raddr_a  (rs1_r),
    .rdata_a  (rs1_data_s),
    .raddr_b  (rs2_r),
    .rdata_b  (rs2_data_s),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and ALU drive decode; ALU operands are held at zero outside EXEC.
  always_comb begin
    state_nxt_s   = state_r;
    instr_ready_s = 1'b0;
    alu_ena_s     = 1'b0;
    alu_op_s      = 2'b00;
    alu_x_s       = {DATA_W{1'b0}};
    alu_y_s       = {DATA_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        instr_ready_s = 1'b1;
        if (instr_valid) begin
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        alu_ena_s   = 1'b1;
        alu_op_s    = op_r;
        alu_x_s     = rs1_data_s;
        alu_y_s     = imm_en_r ? sext(imm_r) : rs2_data_s;
        state_nxt_s = ST_WB;
      end
      ST_WB: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Instruction fields captured at the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r     <= 2'b00;
      rd_r     <= {REG_AW{1'b0}};
      rs1_r    <= {REG_AW{1'b0}};
      rs2_r    <= {REG_AW{1'b0}};
      imm_en_r <= 1'b0;
      imm_r    <= {IMM_W{1'b0}};
    end else if (instr_fire_s) begin
      op_r     <= instr_op;
      rd_r     <= instr_rd;
      rs1_r    <= instr_rs1;
      rs2_r    <= instr_rs2;
      imm_en_r <= instr_imm_en;
      imm_r    <= instr_imm;
    end
  end

  // Retirement: one-cycle strobe, held result and wrapping counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_r   <= 1'b0;
      res_rd_r      <= {REG_AW{1'b0}};
      res_data_r    <= {DATA_W{1'b0}};
      retired_cnt_r <= {CNT_W{1'b0}};
    end else begin
      res_valid_r <= wb_s;
      if (wb_s) begin
        res_rd_r      <= rd_r;
        res_data_r    <= alu_out;
        retired_cnt_r <= retired_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign instr_ready = instr_ready_s;
  assign alu_ena     = alu_ena_s;
  assign alu_op      = alu_op_s;
  assign alu_x       = alu_x_s;
  assign alu_y       = alu_y_s;
  assign res_valid   = res_valid_r;
  assign res_rd      = res_rd_r;
  assign res_data    = res_data_r;
  assign retired_cnt = retired_cnt_r;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: directed vector table, randomized
// instructions against a register-file reference model, and multi-cycle cases.
module tb_alu_exec_ctrl;
  import alu_exec_ctrl_pkg::*;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int IW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_valid, instr_ready;
  logic [1:0]    instr_op;
  logic [AW-1:0] instr_rd, instr_rs1, instr_rs2;
  logic          instr_imm_en;
  logic [IW-1:0] instr_imm;
  logic          alu_ena;
  logic [1:0]    alu_op;
  logic [DW-1:0] alu_x, alu_y, alu_out;
  logic          res_valid;
  logic [AW-1:0] res_rd;
  logic [DW-1:0] res_data;
  logic [CW-1:0] retired_cnt;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.DATA_W(DW), .REG_AW(AW), .IMM_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .instr_imm_en(instr_imm_en), .instr_imm(instr_imm),
    .alu_ena(alu_ena), .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y), .alu_out(alu_out),
    .res_valid(res_valid), .res_rd(res_rd), .res_data(res_data),
    .retired_cnt(retired_cnt), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Stand-in for the 2-bit-op ALU: unreset output register, captures on alu_ena.
  always_ff @(posedge clk) begin
    if (alu_ena) begin
      case (alu_op)
        2'b00:   alu_out <= alu_x + alu_y;
        2'b01:   alu_out <= alu_x - alu_y;
        2'b10:   alu_out <= alu_x & alu_y;
        default: alu_out <= alu_x ^ alu_y;
      endcase
    end
  end

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] m_rf [0:7];
  int unsigned   m_cnt;

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] rd, rs1, rs2;
    logic          imm_en;
    logic [IW-1:0] imm;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    return (a == 3'd0) ? 32'd0 : m_rf[a];
  endfunction

  function automatic logic [DW-1:0] m_operand_y(input logic imm_en, input logic [IW-1:0] imm,
                                                input logic [AW-1:0] rs2);
    return imm_en ? 32'($signed(imm)) : m_read(rs2);
  endfunction

  function automatic logic [DW-1:0] m_alu(input logic [1:0] op, input logic [DW-1:0] x,
                                          input logic [DW-1:0] y);
    case (op)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_AND:  return x & y;
      default: return x ^ y;
    endcase
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 32'd0;
    m_cnt = 0;
  endtask

  task automatic m_retire(input logic [AW-1:0] rd, input logic [DW-1:0] r);
    if (rd != 3'd0) m_rf[rd] = r;
    m_cnt = (m_cnt + 1) % (1 << CW);
  endtask

  task automatic drive_instr(input logic [1:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                             input logic [AW-1:0] rs2, input logic imm_en, input logic [IW-1:0] imm);
    instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
    instr_imm_en = imm_en; instr_imm = imm;
  endtask

  // One instruction, checked cycle by cycle from accept edge N to N+2.
  task automatic issue_chk(input logic [1:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                           input logic [AW-1:0] rs2, input logic imm_en, input logic [IW-1:0] imm,
                           input logic use_exp, input logic [DW-1:0] exp);
    logic [DW-1:0] x, y, r;
    int guard;
    x = m_read(rs1);
    y = m_operand_y(imm_en, imm, rs2);
    r = m_alu(op, x, y);
    @(negedge clk);
    drive_instr(op, rd, rs1, rs2, imm_en, imm);
    instr_valid = 1'b1;
    dbg_addr = rd;
    guard = 0;
    while (!instr_ready && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", instr_ready, 1);
    @(negedge clk);
    instr_valid = 1'b0;
    drive_instr(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 16'($urandom));
    check("exec_ena", alu_ena, 1);
    check("exec_ready", instr_ready, 0);
    check("exec_op", alu_op, op);
    check("exec_x", alu_x, x);
    check("exec_y", alu_y, y);
    check("exec_res_valid", res_valid, 0);
    @(negedge clk);
    check("wb_ena", alu_ena, 0);
    check("wb_x_zero", {alu_x, alu_y}, 64'd0);
    check("wb_res_valid", res_valid, 0);
    @(negedge clk);
    m_retire(rd, r);
    check("ret_valid", res_valid, 1);
    check("ret_rd", res_rd, rd);
    check("ret_data", res_data, r);
    check("ret_cnt", retired_cnt, m_cnt);
    check("ret_dbg", dbg_data, m_read(rd));
    check("ret_ready", instr_ready, 1);
    if (use_exp) check("table_data", res_data, exp);
  endtask

  // Three instructions with instr_valid held high: one accept every 3 cycles.
  task automatic back_to_back();
    logic [1:0]    b_op  [3];
    logic [AW-1:0] b_rd  [3];
    logic [AW-1:0] b_rs1 [3];
    logic [AW-1:0] b_rs2 [3];
    logic          b_ie  [3];
    logic [IW-1:0] b_imm [3];
    int rdy_n, ena_n, res_n, k;
    logic [DW-1:0] r;
    for (int i = 0; i < 3; i++) begin
      b_op[i] = 2'($urandom); b_rd[i] = 3'($urandom_range(7, 1));
      b_rs1[i] = 3'($urandom); b_rs2[i] = 3'($urandom);
      b_ie[i] = 1'($urandom); b_imm[i] = 16'($urandom);
    end
    rdy_n = 0; ena_n = 0; res_n = 0;
    @(negedge clk);
    drive_instr(b_op[0], b_rd[0], b_rs1[0], b_rs2[0], b_ie[0], b_imm[0]);
    instr_valid = 1'b1;
    k = 1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      rdy_n += int'(instr_ready);
      ena_n += int'(alu_ena);
      if (res_valid && res_n < 3) begin
        r = m_alu(b_op[res_n], m_read(b_rs1[res_n]), m_operand_y(b_ie[res_n], b_imm[res_n], b_rs2[res_n]));
        m_retire(b_rd[res_n], r);
        check("b2b_rd", res_rd, b_rd[res_n]);
        check("b2b_data", res_data, r);
        check("b2b_cnt", retired_cnt, m_cnt);
        res_n++;
      end
      if (instr_ready) begin
        if (k < 3) begin
          drive_instr(b_op[k], b_rd[k], b_rs1[k], b_rs2[k], b_ie[k], b_imm[k]);
          k++;
        end else begin
          instr_valid = 1'b0;
        end
      end
    end
    instr_valid = 1'b0;
    check("b2b_ready_cycles", rdy_n, 3);
    check("b2b_ena_cycles", ena_n, 3);
    check("b2b_results", res_n, 3);
  endtask

  initial begin
    rst_n = 1'b0;
    instr_valid = 1'b0;
    drive_instr(2'b00, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000);
    dbg_addr = 3'd1;
    m_reset();

    vecs[0]  = '{OP_ADD, 3'd1, 3'd0, 3'd5, 1'b1, 16'h0005, 32'h0000_0005};
    vecs[1]  = '{OP_ADD, 3'd2, 3'd1, 3'd3, 1'b1, 16'hFFFF, 32'h0000_0004};
    vecs[2]  = '{OP_SUB, 3'd3, 3'd0, 3'd1, 1'b0, 16'h1234, 32'hFFFF_FFFB};
    vecs[3]  = '{OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h00F0, 32'h0000_00F0};
    vecs[4]  = '{OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 16'h003C, 32'h0000_003C};
    vecs[5]  = '{OP_AND, 3'd4, 3'd1, 3'd2, 1'b0, 16'h0000, 32'h0000_0030};
    vecs[6]  = '{OP_XOR, 3'd5, 3'd1, 3'd2, 1'b0, 16'h0000, 32'h0000_00CC};
    vecs[7]  = '{OP_ADD, 3'd0, 3'd0, 3'd0, 1'b1, 16'h0007, 32'h0000_0007};
    vecs[8]  = '{OP_ADD, 3'd6, 3'd0, 3'd0, 1'b1, 16'h0001, 32'h0000_0001};
    vecs[9]  = '{OP_ADD, 3'd7, 3'd6, 3'd6, 1'b0, 16'h0000, 32'h0000_0002};
    vecs[10] = '{OP_SUB, 3'd3, 3'd1, 3'd0, 1'b1, 16'h0010, 32'h0000_00E0};
    vecs[11] = '{OP_XOR, 3'd4, 3'd5, 3'd0, 1'b1, 16'h8000, 32'hFFFF_80CC};

    repeat (3) @(negedge clk);
    check("rst_ready", instr_ready, 1);
    check("rst_ena", alu_ena, 0);
    check("rst_res_valid", res_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cnt", retired_cnt, 0);
    check("rst_res_data", res_data, 0);
    check("rst_dbg", dbg_data, 0);

    for (int i = 0; i < 12; i++) begin
      issue_chk(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm_en, vecs[i].imm,
                1'b1, vecs[i].exp);
    end

    for (int i = 0; i < 40; i++) begin
      issue_chk(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
                16'($urandom), 1'b0, 32'd0);
    end

    back_to_back();
    back_to_back();

    // Reset while in EXEC: instruction discarded, RF cleared.
    @(negedge clk);
    drive_instr(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0009);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    check("mid_exec_ena", alu_ena, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ena", alu_ena, 0);
    check("mid_rst_xy", {alu_x, alu_y}, 64'd0);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_res_data", res_data, 0);
    check("mid_rst_res_rd", res_rd, 0);
    check("mid_rst_cnt", retired_cnt, 0);
    check("mid_rst_ready", instr_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_no_retire", res_valid, 0);
    end
    for (int a = 0; a < 8; a++) begin
      dbg_addr = 3'(a);
      #1;
      check("post_rst_rf_zero", dbg_data, 0);
    end
    check("post_rst_ready", instr_ready, 1);

    // Counter wrap: 2**CW retirements bring it back to zero.
    for (int i = 0; i < (1 << CW); i++) begin
      issue_chk(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
                16'($urandom), 1'b0, 32'd0);
    end
    check("cnt_wrap_zero", retired_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
